decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised decode stage with a built-in instruction queue, sitting between fetch and execute in the rv32i pipeline. It replaces the global-stall interface with valid/ready handshakes on both sides. Fetched instructions are buffered in a DEPTH-entry queue, decoded from the queue head, and registered into a micro-op output register. The block also numbers retiring micro-ops for RVFI ordering and supports a single-cycle flush for branch redirect.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥2
- ORDER_W, 64, width of the order counter
- RESET_PC, 32'h1eceb000, pc reported in out_uop while empty

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- flush  in  1  discard queue and output register this cycle
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  queue can accept; equals !full
- in_pc  in  32  pc of offered instruction
- in_instr  in  32  offered instruction word
- rs1_s, rs2_s  out  5 each  regfile read addresses = head instr[19:15], [24:20]; 0 when queue empty
- out_valid  out  1  out_uop holds a valid micro-op
- out_ready  in  1  execute accepts out_uop
- out_uop  out  de_uop_t  pc, instr, aluop, cmpop, rs1_addr, rs2_addr, rd_addr, illegal, muldiv, muldiv_op
- out_order  out  ORDER_W  sequence number of out_uop

## Operation
- Enqueue on in_valid & in_ready; dequeue the head when the output register loads.
- Output register loads when queue is non-empty & (!out_valid | out_ready).
- Decode of the head:
  - rs1_addr is set for jalr/br/load/store/imm/reg; rs2_addr for br/store/reg; otherwise 0.
  - rd_addr is instr[11:7] for lui/auipc/jal/jalr/load/imm/reg; otherwise 0.
  - aluop/cmpop mapping: slt→blt, sltu→bltu, sr→sra/srl by funct7[5], reg add→sub/add by funct7[5], else aluop=funct3. Unused fields are 0, not x.
  - Unknown opcode, or op_reg with funct7 ∉ {0000000, 0100000} (plus 0000001 when RV32M_EN is defined): illegal=1, all addresses 0.
- Order counter: out_order = counter. The counter increments by 1 on out_valid & out_ready. It wraps modulo 2^ORDER_W and is not reset by flush.
- Flush:
  - Empties the queue, clears out_valid and ignores in_valid that cycle.
  - Flush wins over any simultaneous enqueue, load or handshake. The order counter still increments if out_valid & out_ready held that cycle.
- Full queue: in_ready=0 even if a dequeue occurs the same cycle (no pass-through).
- Empty queue with out_ready=1: out_valid falls after the handshake edge.
- Reset: out_valid=0, in_ready=1, queue empty, counter=0, out_uop.pc=RESET_PC, other out_uop fields 0. Reset mid-operation behaves identically.

## Timing
- Accept at edge t into an empty queue with a free output register → out_valid=1 after edge t+1. Latency is 1 cycle of buffering.
- Sustained throughput is 1 instr/cycle when out_ready stays high.
- Pointers are $clog2(DEPTH) bits and wrap naturally; the count is $clog2(DEPTH)+1 bits.
- in_ready is a registered-state function (depends on count only, not on out_ready).
- out_uop and out_order are stable while out_valid & !out_ready.

## Configuration
- RV32M_EN defined:
  - op_reg with funct7=0000001 decodes as muldiv=1, muldiv_op=funct3, rs1/rs2/rd set, aluop=0.
- RV32M_EN undefined:
  - The same encoding is illegal=1.
  - muldiv and muldiv_op are tied to 0.

## Structure
- rv32i_types package: add de_uop_t struct and muldiv_op_t enum (mul, mulh, mulhsu, mulhu, div, divu, rem, remu). Reuse existing opcode, arith_f3, branch_f3 and alu_op constants.
- Sub-module instr_queue (DEPTH-entry FIFO of {pc, instr}, with push, pop, flush, full and empty). The decoder stays combinational inside decode_queue.

## Test plan
- Reset, then push addi x1,x0,5 at pc 0x1eceb000 → out_valid after 2 edges; aluop=add, rs1_addr=0, rd_addr=1, out_order=0.
- Hold out_ready=0 and push 5 instrs with DEPTH=4 → 4 accepted into the queue plus 1 in the output register. in_ready=0 on the 6th, nothing is lost, and the drain is in order with orders 0..4.
- sub x3,x1,x2 then sra x4,x5,x6 → aluop=sub then sra; rs1/rs2 = 1/2 then 5/6.
- flush while queue is full and out_valid=1 → next cycle out_valid=0, in_ready=1, in_instr offered that cycle is dropped, counter unchanged.
- mul x7,x8,x9 (0x029403b3) → with RV32M_EN: muldiv=1, muldiv_op=0; without it: illegal=1.
- rst_n low mid-stream with 3 queued → all outputs return to their reset values and out_order=0 on the next push.

Source files
------------

// File: rtl/decode_queue_pkg.sv
// Shared rv32i decode types: opcodes, funct3 encodings, ALU ops and the decoded micro-op.
// Consumed by decode_queue and instr_queue.
package decode_queue_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        add  = 3'b000,
        sll  = 3'b001,
        slt  = 3'b010,
        sltu = 3'b011,
        axor = 3'b100,
        sr   = 3'b101,
        aor  = 3'b110,
        aand = 3'b111
    } arith_funct3_t;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef enum logic [2:0] {
        md_mul    = 3'b000,
        md_mulh   = 3'b001,
        md_mulhsu = 3'b010,
        md_mulhu  = 3'b011,
        md_div    = 3'b100,
        md_divu   = 3'b101,
        md_rem    = 3'b110,
        md_remu   = 3'b111
    } muldiv_op_t;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } q_entry_t;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  instr;
        alu_ops           aluop;
        branch_funct3_t   cmpop;
        logic [REG_W-1:0] rs1_addr;
        logic [REG_W-1:0] rs2_addr;
        logic [REG_W-1:0] rd_addr;
        logic             illegal;
        logic             muldiv;
        muldiv_op_t       muldiv_op;
    } de_uop_t;

endpackage

// File: rtl/decode_queue_instr_queue.sv
// DEPTH-entry FIFO of {pc, instr}; flush empties it in one cycle.
module instr_queue
    import decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    input  logic     push,
    input  q_entry_t push_data,
    input  logic     pop,
    output q_entry_t head,
    output logic     full,
    output logic     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    q_entry_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/decode_queue.sv
// Decode stage with built-in instruction queue, valid/ready on both sides, RVFI order counter.
// Define RV32M_EN to decode the M-extension (funct7=0000001) as muldiv micro-ops.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     ORDER_W  = 64,
    parameter logic [XLEN-1:0] RESET_PC = 32'h1eceb000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_instr,
    output logic [REG_W-1:0]   rs1_s,
    output logic [REG_W-1:0]   rs2_s,
    output logic               out_valid,
    input  logic               out_ready,
    output de_uop_t            out_uop,
    output logic [ORDER_W-1:0] out_order
);

    q_entry_t       in_entry;
    q_entry_t       head;
    logic           full;
    logic           empty;
    logic           push;
    logic           load;
    rv32i_opcode    opcode;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    alu_ops         arith_alu;
    branch_funct3_t arith_cmp;
    de_uop_t        dec;

    assign in_entry = '{pc: in_pc, instr: in_instr};
    assign in_ready = ~full;
    assign push     = in_valid & in_ready & ~flush;
    assign load     = ~empty & (~out_valid | out_ready) & ~flush;

    instr_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (in_entry),
        .pop       (load),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign opcode = rv32i_opcode'(head.instr[6:0]);
    assign funct3 = head.instr[14:12];
    assign funct7 = head.instr[31:25];
    assign rs1    = head.instr[19:15];
    assign rs2    = head.instr[24:20];
    assign rd     = head.instr[11:7];

    assign rs1_s = empty ? '0 : rs1;
    assign rs2_s = empty ? '0 : rs2;

    // ALU/compare selection shared by register-immediate and register-register ops.
    always_comb begin
        arith_alu = alu_ops'(funct3);
        arith_cmp = beq;
        case (arith_funct3_t'(funct3))
            slt: begin
                arith_alu = alu_add;
                arith_cmp = blt;
            end
            sltu: begin
                arith_alu = alu_add;
                arith_cmp = bltu;
            end
            sr:  arith_alu = head.instr[30] ? alu_sra : alu_srl;
            add: arith_alu = (opcode == op_reg && head.instr[30]) ? alu_sub : alu_add;
            default: ;
        endcase
    end

    always_comb begin
        dec       = '0;
        dec.pc    = head.pc;
        dec.instr = head.instr;
        case (opcode)
            op_lui, op_auipc, op_jal: dec.rd_addr = rd;
            op_jalr, op_load: begin
                dec.rs1_addr = rs1;
                dec.rd_addr  = rd;
            end
            op_br: begin
                dec.rs1_addr = rs1;
                dec.rs2_addr = rs2;
                dec.cmpop    = branch_funct3_t'(funct3);
            end
            op_store: begin
                dec.rs1_addr = rs1;
                dec.rs2_addr = rs2;
            end
            op_imm: begin
                dec.rs1_addr = rs1;
                dec.rd_addr  = rd;
                dec.aluop    = arith_alu;
                dec.cmpop    = arith_cmp;
            end
            op_reg: begin
                if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                    dec.rs1_addr = rs1;
                    dec.rs2_addr = rs2;
                    dec.rd_addr  = rd;
                    dec.aluop    = arith_alu;
                    dec.cmpop    = arith_cmp;
`ifdef RV32M_EN
                end else if (funct7 == F7_MULDIV) begin
                    dec.rs1_addr  = rs1;
                    dec.rs2_addr  = rs2;
                    dec.rd_addr   = rd;
                    dec.muldiv    = 1'b1;
                    dec.muldiv_op = muldiv_op_t'(funct3);
`endif
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Output register and order counter; flush drops the held micro-op but still counts its handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_uop    <= '0;
            out_uop.pc <= RESET_PC;
            out_order  <= '0;
        end else begin
            if (out_valid && out_ready) out_order <= out_order + ORDER_W'(1);
            if (flush) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid <= 1'b1;
                out_uop   <= dec;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: stimulus queues expected micro-ops, a negedge monitor checks them.
module tb_decode_queue;
    import decode_queue_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_pc;
    logic [31:0]     in_instr;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic            out_valid;
    logic            out_ready;
    de_uop_t         out_uop;
    logic [63:0]     out_order;

    int              checks = 0;
    int              errors = 0;
    de_uop_t         cur_exp;
    de_uop_t         exp_q[$];
    logic [63:0]     exp_order = '0;

    decode_queue #(.DEPTH(4), .ORDER_W(64), .RESET_PC(32'h1eceb000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .rs1_s     (rs1_s),
        .rs2_s     (rs2_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_uop   (out_uop),
        .out_order (out_order)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic de_uop_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                   input logic [2:0] alu, input logic [2:0] cmp,
                                   input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                                   input logic ill, input logic md, input logic [2:0] mdop);
        de_uop_t u;
        u.pc        = pc;
        u.instr     = instr;
        u.aluop     = alu_ops'(alu);
        u.cmpop     = branch_funct3_t'(cmp);
        u.rs1_addr  = r1;
        u.rs2_addr  = r2;
        u.rd_addr   = rd;
        u.illegal   = ill;
        u.muldiv    = md;
        u.muldiv_op = muldiv_op_t'(mdop);
        return u;
    endfunction

    // Monitor: compare each handshaked micro-op, then track flush and accepted pushes.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_order = '0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got pc %0h expected no output", out_uop.pc);
                end else begin
                    check("uop", 128'(out_uop), 128'(exp_q.pop_front()));
                    check("order", out_order, exp_order);
                end
                exp_order = exp_order + 64'd1;
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input de_uop_t e);
        int n = 0;
        cur_exp  = e;
        in_pc    = e.pc;
        in_instr = e.instr;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_timeout", n < 50, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            tick();
            n++;
        end
        check("drain_timeout", n < 100, 1);
    endtask

    task automatic check_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_uop", 128'(out_uop), 128'(mk(32'h1eceb000, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        check("rst_order", out_order, 0);
        check("rst_rs1_s", rs1_s, 0);
        check("rst_rs2_s", rs2_s, 0);
    endtask

    de_uop_t e_addi, e_sub, e_sra, e_xor, e_srli, e_lb, e_sb, e_blt, e_lui, e_bad7, e_badop, e_mul;

    initial begin
        e_addi  = mk(32'h1eceb000, 32'h00500093, alu_add, beq, 0, 0, 1, 0, 0, 0);
        e_sub   = mk(32'h00001000, 32'h402081b3, alu_sub, beq, 1, 2, 3, 0, 0, 0);
        e_sra   = mk(32'h00001004, 32'h4062d233, alu_sra, beq, 5, 6, 4, 0, 0, 0);
        e_xor   = mk(32'h00001008, 32'h003140b3, alu_xor, beq, 2, 3, 1, 0, 0, 0);
        e_srli  = mk(32'h0000100c, 32'h0034d413, alu_srl, beq, 9, 0, 8, 0, 0, 0);
        e_lb    = mk(32'h00001010, 32'h00858503, alu_add, beq, 11, 0, 10, 0, 0, 0);
        e_sb    = mk(32'h00001014, 32'h00c68223, alu_add, beq, 13, 12, 0, 0, 0, 0);
        e_blt   = mk(32'h00001018, 32'h00f74063, alu_add, blt, 14, 15, 0, 0, 0, 0);
        e_lui   = mk(32'h0000101c, 32'h123452b7, alu_add, beq, 0, 0, 5, 0, 0, 0);
        e_bad7  = mk(32'h00001020, 32'h042081b3, alu_add, beq, 0, 0, 0, 1, 0, 0);
        e_badop = mk(32'h00001024, 32'hffffffff, alu_add, beq, 0, 0, 0, 1, 0, 0);
`ifdef RV32M_EN
        e_mul   = mk(32'h00001028, 32'h029403b3, alu_add, beq, 8, 9, 7, 0, 1, 0);
`else
        e_mul   = mk(32'h00001028, 32'h029403b3, alu_add, beq, 0, 0, 0, 1, 0, 0);
`endif

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0; cur_exp = '0;
        tick();
        tick();
        rst_n = 1'b1;
        check_reset();

        // Latency: accept at edge t, out_valid after edge t+1, falls after handshake when empty.
        out_ready = 1'b1;
        cur_exp = e_addi; in_pc = e_addi.pc; in_instr = e_addi.instr; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat_edge1_valid", out_valid, 0);
        tick();
        check("lat_edge2_valid", out_valid, 1);
        tick();
        check("empty_fall_valid", out_valid, 0);

        // Back-to-back decode with out_ready high.
        send(e_sub); send(e_sra); send(e_xor); send(e_srli);
        drain();

        // Backpressure: fill queue plus output register, sixth offer must stall.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b0;
        send(e_sub);
        check("head_rs1_s", rs1_s, 1);
        check("head_rs2_s", rs2_s, 2);
        send(e_sra);
        check("head2_rs1_s", rs1_s, 5);
        check("head2_rs2_s", rs2_s, 6);
        send(e_lb); send(e_sb); send(e_blt);
        check("full_in_ready", in_ready, 0);
        cur_exp = e_lui; in_pc = e_lui.pc; in_instr = e_lui.instr; in_valid = 1'b1;
        tick();
        tick();
        check("stall_valid", out_valid, 1);
        check("stall_uop", 128'(out_uop), 128'(e_sub));
        check("stall_order", out_order, 0);
        out_ready = 1'b1;
        check("full_no_passthru", in_ready, 0);
        send(e_lui);
        drain();

        // Illegal encodings and the M-extension encoding.
        send(e_bad7); send(e_badop); send(e_mul);
        drain();

        // Flush while full with out_valid set; offered instruction is dropped.
        out_ready = 1'b0;
        send(e_xor); send(e_srli); send(e_sub); send(e_sra); send(e_lb);
        check("pre_flush_full", in_ready, 0);
        flush = 1'b1;
        cur_exp = e_lui; in_pc = e_lui.pc; in_instr = e_lui.instr; in_valid = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_order", out_order, exp_order);
        check("flush_rs1_s", rs1_s, 0);
        tick();
        check("flush_dropped", out_valid, 0);

        // Flush coincident with a handshake still advances the order counter.
        send(e_sub); send(e_sra);
        check("fh_valid", out_valid, 1);
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fh_out_valid", out_valid, 0);
        check("fh_order", out_order, exp_order);
        send(e_blt);
        drain();

        // Reset mid-stream with three queued entries.
        out_ready = 1'b0;
        send(e_xor); send(e_srli); send(e_sub); send(e_sra);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset();
        out_ready = 1'b1;
        send(e_addi);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
